// File: rtl/ramio_arbiter_if.sv
// Request port of one RAMIO master and the shared RAMIO bus.
// The arbiter is the slave of each request port and the master of the bus.
interface ramio_req_if;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        err;

  modport master (
    output enable, write_type, read_type,
    output address, data_in,
    input  data_out, done, err
  );
  modport slave (
    input  enable, write_type, read_type,
    input  address, data_in,
    output data_out, done, err
  );
endinterface

interface ramio_bus_if;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (
    output enable, write_type, read_type,
    output address, data_in,
    input  data_out, data_out_ready, busy
  );
  modport slave (
    input  enable, write_type, read_type,
    input  address, data_in,
    output data_out, data_out_ready, busy
  );
endinterface

// File: rtl/ramio_arbiter.sv
// Two-master arbiter/sequencer for the single RAMIO port.
// Serialises whole transactions, round-robin or fixed priority.
module ramio_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         rst,
  ramio_req_if.slave  m0,
  ramio_req_if.slave  m1,
  ramio_bus_if.master ramio
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic        grant_q, last_q;
  logic [1:0]  wt_q;
  logic [2:0]  rt_q;
  logic [31:0] addr_q, din_q, cnt_q;
  logic        en_q;
  logic        d0_q, d1_q, e0_q, e1_q;
  logic [31:0] do0_q, do1_q;

  logic        pick1;
  logic [1:0]  c_wt;
  logic [2:0]  c_rt;
  logic [31:0] c_addr, c_din;
  logic        is_wr, is_null, xfer_ok;

  // On a tie round-robin favours the master not served last
  assign pick1 = (m0.enable && m1.enable)
               ? (FIXED_PRIORITY == 0 && !last_q)
               : m1.enable;

  assign c_wt   = pick1 ? m1.write_type : m0.write_type;
  assign c_rt   = pick1 ? m1.read_type  : m0.read_type;
  assign c_addr = pick1 ? m1.address    : m0.address;
  assign c_din  = pick1 ? m1.data_in    : m0.data_in;

  assign is_wr   = (wt_q != 2'b00);
  assign is_null = !is_wr && (rt_q == 3'b000);
  assign xfer_ok = is_wr ? !ramio.busy
                         : ramio.data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wt_q    <= '0;
      rt_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      e0_q    <= 1'b0;
      e1_q    <= 1'b0;
      do0_q   <= '0;
      do1_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0.enable || m1.enable) begin
            grant_q <= pick1;
            last_q  <= pick1;
            wt_q    <= c_wt;
            rt_q    <= (c_wt != 2'b00) ? 3'b000 : c_rt;
            addr_q  <= c_addr;
            din_q   <= c_din;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_null) begin
            d0_q    <= !grant_q;
            d1_q    <= grant_q;
            e0_q    <= !grant_q;
            e1_q    <= grant_q;
            state_q <= DONE;
          end else if (!ramio.busy) begin
            en_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
          // cnt_q == 0 marks the cycle before RAMIO raises busy
          if (cnt_q != '0 && xfer_ok) begin
            en_q    <= 1'b0;
            d0_q    <= !grant_q;
            d1_q    <= grant_q;
            state_q <= DONE;
            if (!is_wr && !grant_q) do0_q <= ramio.data_out;
            if (!is_wr && grant_q)  do1_q <= ramio.data_out;
          end else if (TMO != '0 && cnt_q == TMO) begin
            en_q    <= 1'b0;
            d0_q    <= !grant_q;
            d1_q    <= grant_q;
            e0_q    <= !grant_q;
            e1_q    <= grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          d0_q    <= 1'b0;
          d1_q    <= 1'b0;
          e0_q    <= 1'b0;
          e1_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ramio.enable     = en_q;
  assign ramio.write_type = wt_q;
  assign ramio.read_type  = rt_q;
  assign ramio.address    = addr_q;
  assign ramio.data_in    = din_q;

  assign m0.done     = d0_q;
  assign m0.err      = e0_q;
  assign m0.data_out = do0_q;
  assign m1.done     = d1_q;
  assign m1.err      = e1_q;
  assign m1.data_out = do1_q;

endmodule

// File: doc/ramio_arbiter.md
# ramio_arbiter

Two-requester arbiter and sequencer for the single RAMIO port. It sits between the RAMIO and two masters: master 0 is the flash boot loader and master 1 is the CPU core. It serialises complete RAMIO transactions, either round-robin or fixed-priority. It drives the RAMIO enable/type/address/data handshake on behalf of the granted master and returns read data and completion status to that master.

## Interface

**Parameters**
- `FIXED_PRIORITY`, default 0. 0 = round-robin; 1 = m0 always wins ties.
- `TIMEOUT_CYCLES`, default 1024. Maximum number of WAIT cycles before abort. 0 disables the timeout.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mN_enable` in 1 (N = 0, 1): request. Held high, with the command stable, until `mN_done`.
- `mN_write_type` in 2: 00 none, 01 byte, 10 half, 11 word.
- `mN_read_type` in 3: 000 none; bit[2] = sign-extend; [1:0] = size as for write.
- `mN_address` in 32: byte address.
- `mN_data_in` in 32: write data.
- `mN_data_out` out 32: last read result. Held until the next read by this master completes.
- `mN_done` out 1: one-cycle completion pulse.
- `mN_err` out 1: valid with `mN_done`. 1 = timeout or null command.
- `ramio_enable` out 1.
- `ramio_write_type` out 2.
- `ramio_read_type` out 3.
- `ramio_address` out 32.
- `ramio_data_in` out 32.
- `ramio_data_out` in 32.
- `ramio_data_out_ready` in 1.
- `ramio_busy` in 1.

## Operation

- **States:** IDLE, ISSUE, WAIT, DONE (2-bit encoding). All outputs are registered.
- **IDLE:**
  - Choose among masters with `mN_enable` = 1.
  - Round-robin: on a tie, the master other than `last_grant` wins.
  - Fixed priority: on a tie, m0 wins.
  - On grant, latch the master's command, set `grant` and `last_grant`, and go to ISSUE.
- **Null command** (write_type = 00 and read_type = 000): go directly to DONE with err = 1. RAMIO is not touched.
- **ISSUE:** wait for `ramio_busy` = 0. Then:
  - drive `ramio_enable` = 1 with the latched type, address and data;
  - clear the timeout counter;
  - go to WAIT.
- **Write vs. read:** if the latched write_type ≠ 00, the transaction is a write and `ramio_read_type` is driven 000. Write takes precedence if both types are nonzero.
- **WAIT:** the first WAIT cycle is ignored, because RAMIO raises busy one cycle late.
  - Write completes on the first subsequent cycle with `ramio_busy` = 0.
  - Read completes on the first subsequent cycle with `ramio_data_out_ready` = 1. On that edge, `mN_data_out` ← `ramio_data_out`.
  - On completion: `ramio_enable` ← 0, `mN_done` ← 1, `mN_err` ← 0, go to DONE.
- **Timeout:** the counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES`:
  - `ramio_enable` ← 0, done ← 1, err ← 1, go to DONE;
  - `data_out` is unchanged.
- **DONE:** lasts exactly one cycle, during which done/err are high. Then done ← 0, err ← 0, and go to IDLE. The master must drop enable on the edge ending the DONE cycle, so it is not re-granted.
- **Non-granted master:** sees no done and is never serviced mid-transaction. Only one transaction is ever outstanding.
- **Command changes:** changes to the granted master's command after the grant are ignored, because the command is latched.
- **Reset:**
  - All outputs go to 0.
  - State → IDLE, `last_grant` = 1 (so m0 wins the first tie), counter = 0.
  - Reset mid-transaction drops `ramio_enable` on the next edge and discards the transaction without a done.

## Timing

- Request to enable:
  - `mN_enable` sampled high in cycle n (IDLE) → ISSUE in n+1.
  - `ramio_enable` is high from n+2 at the earliest (when `ramio_busy` = 0 in n+1).
- Completion to done: write done / read done are high in the cycle after the qualifying `ramio_busy`/`ramio_data_out_ready` cycle.
- Minimum cycles per transaction: 5 (IDLE, ISSUE, WAIT ×2, DONE).
- Back-to-back: a new grant is possible in the IDLE cycle immediately after DONE.
- Simultaneous requests in IDLE: exactly one grant. The loser stays pending and is granted in the next IDLE.
- Timeout: `done`/`err` rise exactly `TIMEOUT_CYCLES`+1 cycles after `ramio_enable` rises.
- Counter width: 32 bits, no wrap within the timeout range.

## Test plan

- **m0 word write:** m0 writes word 0xDEADBEEF to 0x10; RAMIO model holds busy for 2 cycles. Expect:
  - `ramio_write_type` = 11, `ramio_address` = 0x10, `ramio_data_in` = 0xDEADBEEF;
  - `m0_done` as a single pulse with `m0_err` = 0;
  - m1 outputs stay 0.
- **m1 unsigned half read:** m1 reads unsigned half (read_type 010) at 0x4; model asserts ready with 0x00005537 three cycles after enable. Expect:
  - `ramio_read_type` = 010 and `ramio_write_type` = 00;
  - `m1_data_out` = 0x00005537 with a single `m1_done` pulse.
- **Round-robin:** both masters request continuously over 4 transactions.
  - `FIXED_PRIORITY` = 0: grant order m0, m1, m0, m1.
  - `FIXED_PRIORITY` = 1: order m0, m0, m0, m0; m1 is served only after m0 drops its request.
- **Timeout:** `TIMEOUT_CYCLES` = 8, read issued, ready never asserted. Expect:
  - done and err high exactly 9 cycles after `ramio_enable` rises;
  - `ramio_enable` = 0;
  - `data_out` unchanged.
- **Null command:** enable with both types zero → done and err after 2 cycles; `ramio_enable` is never asserted.
- **Reset mid-transaction:** `rst` asserted in WAIT. Expect:
  - all outputs 0 on the next edge;
  - no done;
  - a subsequent simultaneous request is granted to m0 first.
